// File: rtl/tab_stop_engine_pkg.sv
// Shared console definitions: tab command codes, default geometry and the
// default tab-stop bitmap builder used by the tab engine.
package tab_stop_engine_pkg;

    typedef enum logic [2:0] {
        TAB_SET     = 3'd0,
        TAB_CLR_AT  = 3'd1,
        TAB_CLR_ALL = 3'd2,
        TAB_DEFAULT = 3'd3,
        TAB_FWD     = 3'd4,
        TAB_BWD     = 3'd5
    } TabCmd_t;

    localparam int CONSOLE_COLUMNS      = 80;
    localparam int CONSOLE_TAB_INTERVAL = 8;

    // Widest console the bitmap builder supports; callers slice the low bits.
    localparam int MAX_COLUMNS = 1024;
    typedef logic [MAX_COLUMNS-1:0] stop_vec_t;

    function automatic stop_vec_t default_stop_map(input int columns, input int interval);
        stop_vec_t m;
        m = '0;
        for (int k = 0; k < MAX_COLUMNS; k++) begin
            if (k < columns && (k % interval) == 0) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/tab_stop_engine_if.sv
// Command/response bundle between the escape-sequence parser (master) and
// the tab-stop engine (slave), plus the engine's stop bitmap for reporting.
interface tab_stop_engine_if
    import tab_stop_engine_pkg::*;
#(
    parameter int COLUMNS = CONSOLE_COLUMNS
);
    localparam int COL_W = $clog2(COLUMNS);

    logic             cmd_valid;
    logic             cmd_ready;
    TabCmd_t          cmd_type;
    logic [7:0]       cmd_count;
    logic [COL_W-1:0] cur_col;
    logic             pos_valid;
    logic [COL_W-1:0] pos;
    logic [COLUMNS-1:0] stop_map;

    modport master (
        output cmd_valid, cmd_type, cmd_count, cur_col,
        input  cmd_ready, pos_valid, pos, stop_map
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_count, cur_col,
        output cmd_ready, pos_valid, pos, stop_map
    );

endinterface

// File: rtl/tab_stop_engine.sv
// Tab-stop engine: keeps a per-column stop bitmap and walks it one column
// per cycle to resolve forward/backward tab moves.
module tab_stop_engine
    import tab_stop_engine_pkg::*;
#(
    parameter int COLUMNS      = CONSOLE_COLUMNS,
    parameter int TAB_INTERVAL = CONSOLE_TAB_INTERVAL
)(
    input  logic clk,
    input  logic rst,
    tab_stop_engine_if.slave bus
);
    localparam int COL_W = $clog2(COLUMNS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);
    localparam stop_vec_t DEFAULT_FULL = default_stop_map(COLUMNS, TAB_INTERVAL);
    localparam logic [COLUMNS-1:0] DEFAULT_MAP = DEFAULT_FULL[COLUMNS-1:0];

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_reg;
    logic [COL_W-1:0]   now_reg;
    logic [7:0]         rem_reg;
    logic               dir_reg;
    logic [COL_W-1:0]   pos_reg;
    logic               pos_valid_reg;
    logic               cmd_ready_reg;
    logic [COLUMNS-1:0] stop_map_reg;

    logic               at_bound;
    logic [COL_W-1:0]   next_col;
    logic               next_bound;
    logic               next_stop;
    logic               finish;
    logic [COL_W-1:0]   target;
    logic               col_in_range;
    logic [COL_W-1:0]   start_col;

    assign col_in_range = (bus.cur_col <= LAST_COL);
    assign start_col    = col_in_range ? bus.cur_col : LAST_COL;

    // One step of the walk: decide whether this cycle terminates and where.
    always_comb begin
        at_bound   = dir_reg ? (now_reg == LAST_COL) : (now_reg == '0);
        next_col   = dir_reg ? (now_reg + 1'b1) : (now_reg - 1'b1);
        next_bound = dir_reg ? (next_col == LAST_COL) : (next_col == '0);
        next_stop  = 1'b0;
        if (!at_bound) begin
            next_stop = stop_map_reg[next_col];
        end
        finish = at_bound || next_bound || (next_stop && rem_reg == 8'd1);
        target = at_bound ? now_reg : next_col;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            now_reg       <= '0;
            rem_reg       <= 8'd0;
            dir_reg       <= 1'b0;
            pos_reg       <= '0;
            pos_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            stop_map_reg  <= DEFAULT_MAP;
        end else begin
            pos_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_reg) begin
                        case (bus.cmd_type)
                            TAB_SET: begin
                                if (col_in_range) stop_map_reg[bus.cur_col] <= 1'b1;
                            end
                            TAB_CLR_AT: begin
                                if (col_in_range) stop_map_reg[bus.cur_col] <= 1'b0;
                            end
                            TAB_CLR_ALL: stop_map_reg <= '0;
                            TAB_DEFAULT: stop_map_reg <= DEFAULT_MAP;
                            TAB_FWD, TAB_BWD: begin
                                state_reg     <= SCAN;
                                cmd_ready_reg <= 1'b0;
                                now_reg       <= start_col;
                                rem_reg       <= (bus.cmd_count == 8'd0) ? 8'd1 : bus.cmd_count;
                                dir_reg       <= (bus.cmd_type == TAB_FWD);
                            end
                            default: ;
                        endcase
                    end
                end
                SCAN: begin
                    if (finish) begin
                        pos_reg       <= target;
                        pos_valid_reg <= 1'b1;
                        state_reg     <= IDLE;
                        cmd_ready_reg <= 1'b1;
                    end else begin
                        // A stop passed over with rem>1 consumes one count.
                        rem_reg <= rem_reg - {7'd0, next_stop};
                        now_reg <= next_col;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.pos_valid = pos_valid_reg;
    assign bus.pos       = pos_reg;
    assign bus.stop_map  = stop_map_reg;

endmodule

// File: tb/tb_tab_stop_engine.sv
// Directed bench for tab_stop_engine: a vector table of commands with
// hand-computed target column and arrival cycle, plus abort/stall sequences.
module tb_tab_stop_engine;
    import tab_stop_engine_pkg::*;

    localparam int COLS = 80;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tab_stop_engine_if #(.COLUMNS(COLS)) bus ();

    tab_stop_engine #(.COLUMNS(COLS), .TAB_INTERVAL(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        TabCmd_t cmd;
        int      count;
        int      col;
        int      exp_pos;
        int      exp_cyc;
    } vec_t;

    vec_t vecs[24];
    int   nvec = 0;
    int   total = 0;
    int   bad = 0;
    logic [COLS-1:0] model_map;
    logic [COLS-1:0] default_map;

    task automatic add(input TabCmd_t c, input int cnt, input int col,
                       input int p, input int cyc);
        vecs[nvec] = '{cmd: c, count: cnt, col: col, exp_pos: p, exp_cyc: cyc};
        nvec++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_map(input string name);
        total++;
        if (bus.stop_map !== model_map) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, bus.stop_map, model_map);
        end
    endtask

    // Waits for pos_valid; edges0 = edges already elapsed since the accept edge.
    task automatic wait_pos(input string name, input int edges0,
                            input int exp_pos, input int exp_cyc);
        int edges = edges0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (bus.pos_valid !== 1'b1 && edges < 300);
        if (bus.pos_valid !== 1'b1) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            check({name, "_pos"}, int'(bus.pos), exp_pos);
            check({name, "_cycle"}, edges + 1, exp_cyc);
            check({name, "_ready"}, int'(bus.cmd_ready), 1);
            $display("txn %s pos=%0d cycle=%0d", name, bus.pos, edges + 1);
            @(posedge clk); #1;
            check({name, "_pulse"}, int'(bus.pos_valid), 0);
        end
    endtask

    task automatic run_cmd(input string name, input TabCmd_t c, input int cnt,
                           input int col, input int exp_pos, input int exp_cyc);
        check({name, "_ready_pre"}, int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = c;
        bus.cmd_count = 8'(cnt);
        bus.cur_col   = 7'(col);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (c == TAB_FWD || c == TAB_BWD) begin
            wait_pos(name, 0, exp_pos, exp_cyc);
        end else begin
            case (c)
                TAB_SET:     if (col < COLS) model_map[col] = 1'b1;
                TAB_CLR_AT:  if (col < COLS) model_map[col] = 1'b0;
                TAB_CLR_ALL: model_map = '0;
                TAB_DEFAULT: model_map = default_map;
                default: ;
            endcase
            check({name, "_nopos"}, int'(bus.pos_valid), 0);
            check({name, "_ready"}, int'(bus.cmd_ready), 1);
            check_map({name, "_map"});
            $display("txn %s map=%h", name, bus.stop_map);
        end
    endtask

    initial begin
        for (int k = 0; k < COLS; k++) default_map[k] = (k % 8 == 0);
        model_map     = default_map;
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = TAB_SET;
        bus.cmd_count = 8'd0;
        bus.cur_col   = '0;

        add(TAB_FWD, 1, 3, 8, 6);
        add(TAB_FWD, 3, 0, 24, 25);
        add(TAB_FWD, 0, 24, 32, 9);
        add(TAB_FWD, 1, 8, 16, 9);
        add(TAB_BWD, 1, 10, 8, 3);
        add(TAB_BWD, 2, 10, 0, 11);
        add(TAB_BWD, 1, 0, 0, 2);
        add(TAB_BWD, 1, 79, 72, 8);
        add(TAB_CLR_ALL, 0, 0, 0, 0);
        add(TAB_FWD, 1, 5, 79, 75);
        add(TAB_FWD, 1, 79, 79, 2);
        add(TAB_FWD, 1, 100, 79, 2);
        add(TAB_DEFAULT, 0, 0, 0, 0);
        add(TAB_SET, 0, 12, 0, 0);
        add(TAB_CLR_AT, 0, 16, 0, 0);
        add(TAB_FWD, 2, 10, 24, 15);
        add(TAB_SET, 0, 100, 0, 0);
        add(TAB_CLR_AT, 0, 120, 0, 0);
        add(TAB_DEFAULT, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", int'(bus.cmd_ready), 1);
        check("reset_pos_valid", int'(bus.pos_valid), 0);
        check("reset_pos", int'(bus.pos), 0);
        check_map("reset_map");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < nvec; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].count,
                    vecs[i].col, vecs[i].exp_pos, vecs[i].exp_cyc);
        end

        // Command raised during SCAN must be stalled and leave the map alone.
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = TAB_FWD;
        bus.cmd_count = 8'd9;
        bus.cur_col   = 7'd0;
        @(posedge clk); #1;
        bus.cmd_type = TAB_CLR_ALL;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall_ready%0d", i), int'(bus.cmd_ready), 0);
        end
        check_map("stall_map");
        bus.cmd_valid = 1'b0;
        wait_pos("stall_fwd9", 10, 72, 73);
        check_map("stall_map_after");

        // Reset in the middle of a long walk aborts it and restores defaults.
        run_cmd("abort_clr", TAB_CLR_ALL, 0, 0, 0, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = TAB_FWD;
        bus.cmd_count = 8'd1;
        bus.cur_col   = 7'd0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_map = default_map;
        check("abort_ready", int'(bus.cmd_ready), 1);
        check("abort_pos_valid", int'(bus.pos_valid), 0);
        check("abort_pos", int'(bus.pos), 0);
        check_map("abort_map");
        @(posedge clk); #1;
        rst = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 90; i++) begin
                @(posedge clk); #1;
                if (bus.pos_valid === 1'b1) seen++;
            end
            check("abort_no_pulse", seen, 0);
        end
        $display("txn abort done map=%h", bus.stop_map);
        run_cmd("post_abort", TAB_FWD, 1, 3, 8, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
